// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Ticks per bit and the tick index that lands mid start bit
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

    // Clock cycles per oversample tick, rounded to nearest
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        int unsigned den;
        den = OVERSAMPLE * baud_rate;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_rate_gen.sv
// Free-running 16x oversampling tick generator.
module uart_baud_rate_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE = 19200,
    parameter int unsigned CLK_FREQ  = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic baudTick
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Divider counter 0..DIV-1; tick is registered so it is high while cnt == DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            baudTick <= 1'b0;
        end else begin
            if (cnt == CNT_W'(DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            baudTick <= (cnt == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1-style receiver: synchroniser, oversampling FSM and output word register.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned CLK_FREQ   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  baudTick,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  new_byte_indicate
);

    localparam int unsigned N_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned LAST_S = OVERSAMPLE - 1;

    rx_state_t             state;
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic [3:0]            s;
    logic [N_W-1:0]        n;
    logic [DATA_WIDTH-1:0] shreg;

    uart_baud_rate_gen #(
        .BAUD_RATE (BAUD_RATE),
        .CLK_FREQ  (CLK_FREQ)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .baudTick (baudTick)
    );

    assign rx_s = rx_sync[1];

    // Two-flop synchroniser for the asynchronous line, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    // Receive FSM with registered status/strobe/data outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            s                 <= '0;
            n                 <= '0;
            shreg             <= '0;
            dataOut           <= '0;
            rx_ready          <= 1'b1;
            new_byte_indicate <= 1'b0;
        end else begin
            new_byte_indicate <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        s        <= '0;
                        rx_ready <= 1'b0;
                    end
                end
                START: begin
                    if (baudTick) begin
                        if (s == 4'(MID_SAMPLE)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                // Start bit vanished before its midpoint: glitch
                                state    <= IDLE;
                                rx_ready <= 1'b1;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (baudTick) begin
                        if (s == 4'(LAST_S)) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                            if (n == N_W'(DATA_WIDTH - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + N_W'(1);
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (baudTick) begin
                        if (s == 4'(LAST_S)) begin
                            state    <= IDLE;
                            rx_ready <= 1'b1;
                            // Only a high stop bit publishes the word
                            if (rx_s) begin
                                dataOut           <= shreg;
                                new_byte_indicate <= 1'b1;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table plus corner sequences.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BIT_NS = 52083;
    localparam int DIV    = 163;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       baudTick;
    logic       rx_ready;
    logic [7:0] dataOut;
    logic       new_byte_indicate;

    int         checks;
    int         errors;
    int         cyc;
    logic       mid_ready;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       jit;
        int         idle_bits;
        logic       exp_strobe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_receiver #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (19200),
        .CLK_FREQ   (50_000_000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx                (rx),
        .baudTick          (baudTick),
        .rx_ready          (rx_ready),
        .dataOut           (dataOut),
        .new_byte_indicate (new_byte_indicate)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every strobe together with the word presented in that cycle
    always @(negedge clk) begin
        if (new_byte_indicate) got_q.push_back(dataOut);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int jitter(input logic en);
        if (!en) return 0;
        return (int'($urandom_range(2, 0)) - 1) * 20;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic jit);
        rx = 1'b0;
        #(BIT_NS + jitter(jit));
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 4) begin
                #(BIT_NS / 2);
                mid_ready = rx_ready;
                #(BIT_NS - BIT_NS / 2 + jitter(jit));
            end else begin
                #(BIT_NS + jitter(jit));
            end
        end
        if (stop) begin
            rx = 1'b1;
            #(BIT_NS + jitter(jit));
        end else begin
            // Low through the stop-bit midpoint, released before the bit ends
            rx = 1'b0;
            #(BIT_NS * 3 / 4);
            rx = 1'b1;
            #(BIT_NS / 4);
        end
    endtask

    task automatic wait_tick(output int at, output logic seen);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (baudTick) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
        end
    endtask

    initial begin
        int   t0, t1;
        logic seen;

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        rx     = 1'b1;
        mid_ready = 1'b1;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0, 1'b1, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1, 1'b1, 8'h3C};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 2, 1'b0, 8'h3C};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 1, 1'b1, 8'h81};

        // Reset values
        repeat (5) @(negedge clk);
        check("reset_baudTick", 32'(baudTick), 32'd0);
        check("reset_rx_ready", 32'(rx_ready), 32'd1);
        check("reset_dataOut", 32'(dataOut), 32'h00);
        check("reset_strobe", 32'(new_byte_indicate), 32'd0);
        rst = 1'b0;

        // Idle line: tick period, tick width, quiet receiver
        wait_tick(t0, seen);
        check("first_tick_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("tick_width", 32'(baudTick), 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_tick(t1, seen);
            check("tick_period", 32'(t1 - t0), 32'(DIV));
            t0 = t1;
        end
        #(BIT_NS * 10);
        @(negedge clk);
        check("idle_strobes", 32'(got_q.size()), 32'd0);
        check("idle_dataOut", 32'(dataOut), 32'h00);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);

        // Frame table: valid, back-to-back with jitter, framing error, recovery
        for (int v = 0; v < 6; v++) begin
            got_q.delete();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].jit);
            if (vecs[v].idle_bits > 0) #(BIT_NS * vecs[v].idle_bits);
            @(negedge clk);
            check($sformatf("vec%0d_mid_ready", v), 32'(mid_ready), 32'd0);
            check($sformatf("vec%0d_strobes", v), 32'(got_q.size()), 32'(vecs[v].exp_strobe));
            if (got_q.size() > 0)
                check($sformatf("vec%0d_strobe_data", v), 32'(got_q[0]), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_dataOut", v), 32'(dataOut), 32'(vecs[v].exp_data));
            if (vecs[v].idle_bits > 0)
                check($sformatf("vec%0d_rx_ready", v), 32'(rx_ready), 32'd1);
        end

        // Short low glitch on an idle line
        got_q.delete();
        rx = 1'b0;
        #2000;
        rx = 1'b1;
        #(BIT_NS * 2);
        @(negedge clk);
        check("glitch_strobes", 32'(got_q.size()), 32'd0);
        check("glitch_dataOut", 32'(dataOut), 32'h81);
        check("glitch_rx_ready", 32'(rx_ready), 32'd1);

        // Reset asserted in the middle of data bit 4
        got_q.delete();
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS / 2);
        @(negedge clk);
        check("midframe_busy", 32'(rx_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd1);
        check("midrst_dataOut", 32'(dataOut), 32'h00);
        check("midrst_strobe", 32'(new_byte_indicate), 32'd0);
        check("midrst_baudTick", 32'(baudTick), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #(BIT_NS * 2);
        @(negedge clk);
        check("midrst_no_strobe", 32'(got_q.size()), 32'd0);

        got_q.delete();
        send_frame(8'h12, 1'b1, 1'b0);
        #(BIT_NS);
        @(negedge clk);
        check("post_rst_strobes", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0)
            check("post_rst_data", 32'(got_q[0]), 32'h12);
        check("post_rst_dataOut", 32'(dataOut), 32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
